imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate generator for the RV32/RV64 decode path. It accepts an instruction word plus a pass-through tag over a valid/ready handshake. It classifies the instruction format from the opcode and emits one selected, XLEN-wide sign- or zero-extended immediate with a format code and an illegal flag. It sits between fetch/IR capture and the register-read stage, and uses a 2-entry skid buffer so that `in_ready` is driven from a register.

---
 rtl/imm_gen_stage.sv | 197 +++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined RV32/RV64 immediate generator with a 2-entry skid buffer.
//
// Decodes the instruction format from the opcode, builds the XLEN-wide
// immediate combinationally from in_ir and captures it (with the format code,
// illegal flag and pass-through tag) into a main/skid register pair.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   flush        synchronous flush; clears both entries, ignores accept
//   in_valid     instruction offered
//   in_ready     stage can accept (inverse of skid valid, register-driven)
//   in_ir        32-bit instruction word
//   in_tag       TAG_W-bit sideband (normally the PC)
//   out_valid    main entry holds a result
//   out_ready    downstream accepts the result
//   out_imm      XLEN-bit extended immediate
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 Z
//   out_illegal  unhandled opcode or reserved shift encoding
//   out_tag      tag of the presented instruction
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic               w_f3_shift;
  logic               w_sh_wide;
  fmt_e               w_fmt;
  logic               w_illegal;
  logic signed [31:0] w_sel32;
  logic [XLEN-1:0]    w_imm;

  assign w_opc      = in_ir[6:0];
  assign w_f3       = in_ir[14:12];
  assign w_f3_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  // Only RV64 OP-IMM shifts use the 6-bit shamt; everything else uses 5 bits
  // and treats ir[25] as a reserved bit.
  assign w_sh_wide  = (XLEN == 64) && (w_opc == OPC_OP_IMM);

  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_LOAD, OPC_JALR: w_fmt = FMT_I;
      OPC_OP_IMM:         w_fmt = w_f3_shift ? FMT_SH : FMT_I;
      OPC_STORE:          w_fmt = FMT_S;
      OPC_BRANCH:         w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_SYSTEM:         w_fmt = w_f3[2] ? FMT_Z : FMT_I;
      OPC_OP_IMM32: begin
        if (XLEN == 64) w_fmt = w_f3_shift ? FMT_SH : FMT_I;
        else            w_illegal = 1'b1;
      end
      OPC_OP, OPC_OP32:   w_fmt = FMT_NONE;
      default:            w_illegal = 1'b1;
    endcase
    if ((w_fmt == FMT_SH) && !w_sh_wide && in_ir[25]) w_illegal = 1'b1;
  end

  // Every immediate fits in a signed 32-bit value (zero-extended fields have a
  // clear sign bit), so one sign extension to XLEN covers all formats.
  always_comb begin
    w_sel32 = '0;
    case (w_fmt)
      FMT_I:  w_sel32 = {{20{in_ir[31]}}, in_ir[31:20]};
      FMT_S:  w_sel32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      FMT_B:  w_sel32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25],
                         in_ir[11:8], 1'b0};
      FMT_U:  w_sel32 = {in_ir[31:12], 12'b0};
      FMT_J:  w_sel32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20],
                         in_ir[30:21], 1'b0};
      FMT_SH: w_sel32 = w_sh_wide ? {26'b0, in_ir[25:20]} : {27'b0, in_ir[24:20]};
      FMT_Z:  w_sel32 = {27'b0, in_ir[19:15]};
      default: w_sel32 = '0;
    endcase
  end

  assign w_imm = XLEN'(w_sel32);

  // ---------------------------------------------------------------------------
  // Two-entry storage: main drives the outputs, skid absorbs one extra accept
  // ---------------------------------------------------------------------------
  logic            r_m_vld, r_s_vld;
  logic [XLEN-1:0] r_m_imm, r_s_imm;
  fmt_e            r_m_fmt, r_s_fmt;
  logic            r_m_ill, r_s_ill;
  logic [TAG_W-1:0] r_m_tag, r_s_tag;

  logic w_acc, w_drn;
  logic w_load_main_new, w_load_main_skid, w_load_skid;
  logic w_m_vld_nxt, w_s_vld_nxt;

  assign w_acc = in_valid & ~r_s_vld;
  assign w_drn = r_m_vld & out_ready;

  // An accept is only possible with skid empty, so skid->main and new->main
  // never coincide.
  assign w_load_main_skid = w_drn & r_s_vld;
  assign w_load_main_new  = w_acc & (~r_m_vld | w_drn);
  assign w_load_skid      = w_acc & r_m_vld & ~w_drn;
  assign w_m_vld_nxt      = w_load_main_new | w_load_main_skid | (r_m_vld & ~w_drn);
  assign w_s_vld_nxt      = w_load_skid | (r_s_vld & ~w_drn);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_m_imm <= '0;
      r_s_imm <= '0;
      r_m_fmt <= FMT_NONE;
      r_s_fmt <= FMT_NONE;
      r_m_ill <= 1'b0;
      r_s_ill <= 1'b0;
      r_m_tag <= '0;
      r_s_tag <= '0;
    end else if (flush) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else begin
      r_m_vld <= w_m_vld_nxt;
      r_s_vld <= w_s_vld_nxt;
      if (w_load_main_new) begin
        r_m_imm <= w_imm;
        r_m_fmt <= w_fmt;
        r_m_ill <= w_illegal;
        r_m_tag <= in_tag;
      end else if (w_load_main_skid) begin
        r_m_imm <= r_s_imm;
        r_m_fmt <= r_s_fmt;
        r_m_ill <= r_s_ill;
        r_m_tag <= r_s_tag;
      end
      if (w_load_skid) begin
        r_s_imm <= w_imm;
        r_s_fmt <= w_fmt;
        r_s_ill <= w_illegal;
        r_s_tag <= in_tag;
      end
    end
  end

  assign in_ready    = ~r_s_vld;
  assign out_valid   = r_m_vld;
  assign out_imm     = r_m_imm;
  assign out_fmt     = r_m_fmt;
  assign out_illegal = r_m_ill;
  assign out_tag     = r_m_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; directed vectors, handshake corner cases and a random run
// checked against a queue-based reference model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_ir(in_ir), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference decode computed with arithmetic shifts on the sign-extended word.
  function automatic void ref_dec(input logic [31:0] ir, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint s, t;
    logic [6:0] op;
    logic [2:0] f3;
    s   = longint'($signed(ir));
    op  = ir[6:0];
    f3  = ir[14:12];
    imm = '0;
    fmt = 3'd0;
    ill = 1'b0;
    case (op)
      7'b0000011, 7'b1100111: fmt = 3'd1;
      7'b0010011: fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
      7'b0100011: fmt = 3'd2;
      7'b1100011: fmt = 3'd3;
      7'b0110111, 7'b0010111: fmt = 3'd4;
      7'b1101111: fmt = 3'd5;
      7'b1110011: fmt = f3[2] ? 3'd7 : 3'd1;
      7'b0011011: begin
        if (x64) fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd1;
        else     ill = 1'b1;
      end
      7'b0110011, 7'b0111011: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    case (fmt)
      3'd1: begin t = s >>> 20; imm = t; end
      3'd2: begin t = s >>> 25; imm = 64'(t << 5) | 64'(ir[11:7]); end
      3'd3: begin
        t = s >>> 31;
        imm = 64'(t << 12) | (64'(ir[7]) << 11) | (64'(ir[30:25]) << 5) | (64'(ir[11:8]) << 1);
      end
      3'd4: begin t = longint'($signed(ir & 32'hFFFFF000)); imm = t; end
      3'd5: begin
        t = s >>> 31;
        imm = 64'(t << 20) | (64'(ir[19:12]) << 12) | (64'(ir[20]) << 11) | (64'(ir[30:21]) << 1);
      end
      3'd6: begin
        if (x64 && op == 7'b0010011) imm = 64'(ir[25:20]);
        else begin
          imm = 64'(ir[24:20]);
          if (ir[25]) ill = 1'b1;
        end
      end
      3'd7: imm = 64'(ir[19:15]);
      default: imm = '0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic        i32;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic        i64;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] tag;
  } ent_t;

  vec_t vecs[15];
  ent_t q[$];

  task automatic chk_zero(input string nm);
    chk({nm, "_vld32"}, 64'(vld32), 64'd0);
    chk({nm, "_imm32"}, 64'(imm32), 64'd0);
    chk({nm, "_fmt32"}, 64'(fmt32), 64'd0);
    chk({nm, "_ill32"}, 64'(ill32), 64'd0);
    chk({nm, "_tag32"}, 64'(tag32), 64'd0);
    chk({nm, "_rdy32"}, 64'(rdy32), 64'd1);
    chk({nm, "_vld64"}, 64'(vld64), 64'd0);
    chk({nm, "_imm64"}, imm64, 64'd0);
    chk({nm, "_fmt64"}, 64'(fmt64), 64'd0);
    chk({nm, "_ill64"}, 64'(ill64), 64'd0);
    chk({nm, "_tag64"}, 64'(tag64), 64'd0);
    chk({nm, "_rdy64"}, 64'(rdy64), 64'd1);
  endtask

  task automatic offer(input logic [31:0] tag);
    in_valid = 1'b1;
    in_ir    = 32'hFFF00093;
    in_tag   = tag;
  endtask

  initial begin
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    logic [6:0]  opcs[13];

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h00112623, 32'h0000000C, 3'd2, 1'b0, 64'h000000000000000C, 3'd2, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[3]  = '{32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[4]  = '{32'h02009093, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000020, 3'd6, 1'b0};
    vecs[5]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0};
    vecs[6]  = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[7]  = '{32'h3400D073, 32'h00000001, 3'd7, 1'b0, 64'h0000000000000001, 3'd7, 1'b0};
    vecs[8]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[9]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[10] = '{32'hFFF0009B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[11] = '{32'h0200909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd6, 1'b1};
    vecs[12] = '{32'h43F0D093, 32'h0000001F, 3'd6, 1'b1, 64'h000000000000003F, 3'd6, 1'b0};
    vecs[13] = '{32'h002080BB, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[14] = '{32'hFE113C23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};

    opcs = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011, 7'b1100011,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0011011,
             7'b0110011, 7'b0111011, 7'b1111111};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) cyc();
    chk_zero("reset");
    rst_n = 1'b1;
    cyc();
    chk_zero("post_reset");

    // Directed vectors, back-to-back with out_ready high.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_ir    = vecs[i].ir;
      in_tag   = 32'(100 + i);
      cyc();
      chk("vec_vld32", 64'(vld32), 64'd1);
      chk("vec_imm32", 64'(imm32), 64'(vecs[i].imm32));
      chk("vec_fmt32", 64'(fmt32), 64'(vecs[i].f32));
      chk("vec_ill32", 64'(ill32), 64'(vecs[i].i32));
      chk("vec_tag32", 64'(tag32), 64'(100 + i));
      chk("vec_imm64", imm64, vecs[i].imm64);
      chk("vec_fmt64", 64'(fmt64), 64'(vecs[i].f64));
      chk("vec_ill64", 64'(ill64), 64'(vecs[i].i64));
      chk("vec_tag64", 64'(tag64), 64'(100 + i));
    end
    in_valid = 1'b0;
    cyc();
    chk("vec_drained", 64'(vld32), 64'd0);

    // Backpressure: tags 1,2,3 offered with out_ready low.
    out_ready = 1'b0;
    offer(32'd1); cyc();
    chk("bp_rdy_after1", 64'(rdy32), 64'd1);
    offer(32'd2); cyc();
    chk("bp_rdy_after2", 64'(rdy32), 64'd0);
    offer(32'd3);
    for (int unsigned k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_rdy", 64'(rdy32), 64'd0);
      chk("bp_hold_vld", 64'(vld32), 64'd1);
      chk("bp_hold_tag", 64'(tag32), 64'd1);
      chk("bp_hold_imm", 64'(imm32), 64'hFFFFFFFF);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_rel_tag2", 64'(tag32), 64'd2);
    chk("bp_rel_rdy", 64'(rdy32), 64'd1);
    cyc();
    chk("bp_rel_vld3", 64'(vld32), 64'd1);
    chk("bp_rel_tag3", 64'(tag32), 64'd3);
    in_valid = 1'b0;
    cyc();
    chk("bp_empty", 64'(vld32), 64'd0);

    // Flush with both entries full and an instruction offered.
    out_ready = 1'b0;
    offer(32'h11); cyc();
    offer(32'h12); cyc();
    offer(32'h13); flush = 1'b1; cyc();
    chk("fl_full_vld", 64'(vld32), 64'd0);
    chk("fl_full_rdy", 64'(rdy32), 64'd1);
    flush = 1'b0; in_valid = 1'b0; cyc();
    chk("fl_full_nocap", 64'(vld32), 64'd0);
    // Flush with only main full, so the offer would otherwise be accepted.
    offer(32'h14); cyc();
    offer(32'h15); flush = 1'b1; cyc();
    chk("fl_one_vld", 64'(vld32), 64'd0);
    chk("fl_one_rdy", 64'(rdy32), 64'd1);
    flush = 1'b0; in_valid = 1'b0; cyc();
    chk("fl_one_nocap", 64'(vld64), 64'd0);

    // Asynchronous reset mid-stream.
    offer(32'h21); cyc();
    offer(32'h22); cyc();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("async_rst_after", 64'(vld32), 64'd0);

    // Random traffic against the queue model.
    q.delete();
    for (int unsigned c = 0; c < 3000; c++) begin
      chk("rnd_vld32", 64'(vld32), 64'(q.size() > 0));
      chk("rnd_vld64", 64'(vld64), 64'(q.size() > 0));
      chk("rnd_rdy32", 64'(rdy32), 64'(q.size() < 2));
      chk("rnd_rdy64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        ref_dec(q[0].ir, 1'b0, e_imm, e_fmt, e_ill);
        chk("rnd_imm32", 64'(imm32), 64'(e_imm[31:0]));
        chk("rnd_fmt32", 64'(fmt32), 64'(e_fmt));
        chk("rnd_ill32", 64'(ill32), 64'(e_ill));
        chk("rnd_tag32", 64'(tag32), 64'(q[0].tag));
        ref_dec(q[0].ir, 1'b1, e_imm, e_fmt, e_ill);
        chk("rnd_imm64", imm64, e_imm);
        chk("rnd_fmt64", 64'(fmt64), 64'(e_fmt));
        chk("rnd_ill64", 64'(ill64), 64'(e_ill));
        chk("rnd_tag64", 64'(tag64), 64'(q[0].tag));
      end
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 60) == 0;
      in_ir     = $urandom;
      in_ir[6:0] = opcs[$urandom_range(0, 12)];
      if ($urandom % 8 == 0) in_ir[6:0] = 7'($urandom);
      in_tag    = $urandom;
      if (flush) q.delete();
      else begin
        bit acc;
        acc = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back('{in_ir, in_tag});
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
